// File: rtl/regfile_scoreboard.sv
// Register file with a per-register load scoreboard.
// Two write ports (ALU on port 0, load return on port 1), two combinational
// read ports with write-through bypass, and a busy bit per register that is
// set by load issue and cleared by load writeback. Optionally the top
// register is a hardwired zero.

// One register word plus its busy bit.
module regfile_scoreboard_cell #(
    parameter int N  = 64,
    parameter bit HZ = 1'b0   // hardwired-zero register: never written, never busy
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         we0_i,
    input  logic [N-1:0] wd0_i,
    input  logic         we1_i,
    input  logic [N-1:0] wd1_i,
    input  logic         set_busy_i,
    input  logic         clr_busy_i,
    output logic [N-1:0] q_o,
    output logic         busy_o,
    output logic         busy_d_o
);
    logic [N-1:0] q_q, q_d;
    logic         busy_q, busy_d;

    // Next state: port 1 overrides port 0; a claim overrides a clear.
    always_comb begin
        q_d    = q_q;
        busy_d = busy_q;
        if (we1_i)
            q_d = wd1_i;
        else if (we0_i)
            q_d = wd0_i;
        if (clr_busy_i)
            busy_d = 1'b0;
        if (set_busy_i)
            busy_d = 1'b1;
        if (HZ) begin
            q_d    = '0;
            busy_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            busy_q <= busy_d;
        end
    end

    assign q_o      = q_q;
    assign busy_o   = busy_q;
    assign busy_d_o = busy_d;
endmodule

module regfile_scoreboard #(
    parameter int N        = 64,
    parameter int REGS     = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] select_a,
    input  logic [AW-1:0] select_b,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic          busy_a,
    output logic          busy_b,
    input  logic          wr_en0,
    input  logic [AW-1:0] wr_addr0,
    input  logic [N-1:0]  wr_data0,
    input  logic          wr_en1,
    input  logic [AW-1:0] wr_addr1,
    input  logic [N-1:0]  wr_data1,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_addr,
    output logic [AW:0]   busy_count
);
    localparam logic [AW-1:0] LAST = AW'(REGS - 1);

    logic [REGS-1:0][N-1:0] regs_q;
    logic [REGS-1:0]        busy_q;
    logic [REGS-1:0]        busy_d;
    logic                   acc0, acc1;
    logic [AW:0]            busy_count_q, busy_count_d;

    // Write acceptance: nothing lands during reset, the zero register ignores
    // writes, and port 0 is dropped if its target is awaiting a load (WAW).
    always_comb begin
        acc1 = wr_en1 && !reset && !(ZERO_REG && (wr_addr1 == LAST));
        acc0 = wr_en0 && !reset && !busy_q[wr_addr0]
               && !(ZERO_REG && (wr_addr0 == LAST));
    end

    for (genvar i = 0; i < REGS; i++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(i);
        regfile_scoreboard_cell #(
            .N  (N),
            .HZ (ZERO_REG && (i == REGS - 1))
        ) u_cell (
            .clock      (clock),
            .reset      (reset),
            .we0_i      (acc0 && (wr_addr0 == IDX)),
            .wd0_i      (wr_data0),
            .we1_i      (acc1 && (wr_addr1 == IDX)),
            .wd1_i      (wr_data1),
            .set_busy_i (claim_en && (claim_addr == IDX)),
            .clr_busy_i (wr_en1 && (wr_addr1 == IDX)),
            .q_o        (regs_q[i]),
            .busy_o     (busy_q[i]),
            .busy_d_o   (busy_d[i])
        );
    end

    // Read with bypass of accepted writes; port 1 data has priority.
    // The zero register never accepts a write, so it falls through to 0.
    always_comb begin
        out_a = regs_q[select_a];
        if (acc1 && (wr_addr1 == select_a))
            out_a = wr_data1;
        else if (acc0 && (wr_addr0 == select_a))
            out_a = wr_data0;
        out_b = regs_q[select_b];
        if (acc1 && (wr_addr1 == select_b))
            out_b = wr_data1;
        else if (acc0 && (wr_addr0 == select_b))
            out_b = wr_data0;
    end

    // A register stops reporting busy in the cycle its load returns,
    // unless a fresh claim to it arrives in that same cycle.
    always_comb begin
        busy_a = busy_q[select_a] && !(wr_en1 && (wr_addr1 == select_a)
                 && !(claim_en && (claim_addr == select_a)));
        busy_b = busy_q[select_b] && !(wr_en1 && (wr_addr1 == select_b)
                 && !(claim_en && (claim_addr == select_b)));
    end

    // Population count of the busy bits as they will be after this edge.
    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < REGS; i++)
            busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
    end

    // Registered busy count.
    always_ff @(posedge clock) begin
        if (reset)
            busy_count_q <= '0;
        else
            busy_count_q <= busy_count_d;
    end

    assign busy_count = busy_count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives two configurations (64x32 with zero register, 16x8 without) from a
// shared stimulus stream; a behavioural model predicts each cycle's outputs,
// and a monitor compares them on the falling edge.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, we0 = 1'b0, we1 = 1'b0, cl = 1'b0;
    logic [4:0]  a0 = '0, a1 = '0, ca = '0, sa = '0, sb = '0;
    logic [63:0] d0 = '0, d1 = '0;

    logic [63:0] oa0, ob0;
    logic        ba0, bb0;
    logic [5:0]  bc0;
    logic [15:0] oa1, ob1;
    logic        ba1, bb1;
    logic [3:0]  bc1;

    regfile_scoreboard #(.N(64), .REGS(32), .AW(5), .ZERO_REG(1'b1)) u0 (
        .clock(clk), .reset(rst), .select_a(sa), .select_b(sb),
        .out_a(oa0), .out_b(ob0), .busy_a(ba0), .busy_b(bb0),
        .wr_en0(we0), .wr_addr0(a0), .wr_data0(d0),
        .wr_en1(we1), .wr_addr1(a1), .wr_data1(d1),
        .claim_en(cl), .claim_addr(ca), .busy_count(bc0));

    regfile_scoreboard #(.N(16), .REGS(8), .AW(3), .ZERO_REG(1'b0)) u1 (
        .clock(clk), .reset(rst), .select_a(sa[2:0]), .select_b(sb[2:0]),
        .out_a(oa1), .out_b(ob1), .busy_a(ba1), .busy_b(bb1),
        .wr_en0(we0), .wr_addr0(a0[2:0]), .wr_data0(d0[15:0]),
        .wr_en1(we1), .wr_addr1(a1[2:0]), .wr_data1(d1[15:0]),
        .claim_en(cl), .claim_addr(ca[2:0]), .busy_count(bc1));

    typedef struct {
        logic [63:0] oa, ob;
        bit          ba, bb;
        int          cnt;
    } exp_t;

    // Reference state: contents and busy flags per configuration.
    logic [63:0] m_reg [2][32];
    bit          m_busy[2][32];
    exp_t        q0[$], q1[$];
    bit          chk_vld = 1'b0;
    int          errors = 0, checks = 0;

    function automatic logic [63:0] mread(input int k, input int sel, input bit zr,
                                          input bit acc0, input bit acc1,
                                          input int xa0, input int xa1,
                                          input logic [63:0] x0, input logic [63:0] x1);
        if (zr && sel == 31) return 64'h0;
        if (acc1 && xa1 == sel) return x1;
        if (acc0 && xa0 == sel) return x0;
        return m_reg[k][sel];
    endfunction

    function automatic bit mbusy(input int k, input int sel, input int xa1, input int xca);
        return m_busy[k][sel] && !(we1 && xa1 == sel && !(cl && xca == sel));
    endfunction

    // Predict this cycle's outputs for configuration k, then advance to the post-edge state.
    task automatic model_step(input int k, input bit chk);
        int          msk, xa0, xa1, xca, xsa, xsb, n;
        bit          zr, acc0, acc1;
        logic [63:0] dm, x0, x1;
        exp_t        e;
        msk = (k == 0) ? 31 : 7;
        zr  = (k == 0);
        dm  = (k == 0) ? {64{1'b1}} : 64'hFFFF;
        xa0 = int'(a0) & msk;  xa1 = int'(a1) & msk;  xca = int'(ca) & msk;
        xsa = int'(sa) & msk;  xsb = int'(sb) & msk;
        x0  = d0 & dm;  x1 = d1 & dm;
        acc1 = we1 && !rst && !(zr && xa1 == 31);
        acc0 = we0 && !rst && !m_busy[k][xa0] && !(zr && xa0 == 31);
        if (chk) begin
            e.oa = mread(k, xsa, zr, acc0, acc1, xa0, xa1, x0, x1);
            e.ob = mread(k, xsb, zr, acc0, acc1, xa0, xa1, x0, x1);
            e.ba = mbusy(k, xsa, xa1, xca);
            e.bb = mbusy(k, xsb, xa1, xca);
            n = 0;
            for (int i = 0; i <= msk; i++) if (m_busy[k][i]) n++;
            e.cnt = n;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = 64'h0;
                m_busy[k][i] = 1'b0;
            end
        end else begin
            if (acc0) m_reg[k][xa0] = x0;
            if (acc1) m_reg[k][xa1] = x1;
            if (we1) m_busy[k][xa1] = 1'b0;
            if (cl && !(zr && xca == 31)) m_busy[k][xca] = 1'b1;
        end
    endtask

    task automatic cyc(input bit r, input bit w0, input int ad0, input logic [63:0] dd0,
                       input bit w1, input int ad1, input logic [63:0] dd1,
                       input bit c, input int cad, input int s_a, input int s_b);
        @(posedge clk);
        #1;
        rst = r;  we0 = w0;  a0 = 5'(ad0);  d0 = dd0;
        we1 = w1; a1 = 5'(ad1); d1 = dd1;
        cl = c;   ca = 5'(cad); sa = 5'(s_a); sb = 5'(s_b);
        chk_vld = !r;
        model_step(0, !r);
        model_step(1, !r);
    endtask

    task automatic rd(input int s_a, input int s_b);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, s_a, s_b);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per configuration whenever a cycle is checkable.
    always @(negedge clk) begin
        exp_t e;
        if (chk_vld) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got none expected an entry");
            end else begin
                e = q0.pop_front();
                chk("u0.out_a", oa0, e.oa);
                chk("u0.out_b", ob0, e.ob);
                chk("u0.busy_a", 64'(ba0), 64'(e.ba));
                chk("u0.busy_b", 64'(bb0), 64'(e.bb));
                chk("u0.busy_count", 64'(bc0), 64'(e.cnt));
                e = q1.pop_front();
                chk("u1.out_a", 64'(oa1), e.oa);
                chk("u1.out_b", 64'(ob1), e.ob);
                chk("u1.busy_a", 64'(ba1), 64'(e.ba));
                chk("u1.busy_b", 64'(bb1), 64'(e.bb));
                chk("u1.busy_count", 64'(bc1), 64'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ad0, ad1, cad;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = 64'h0;
                m_busy[k][i] = 1'b0;
            end
        // Reset, then every address reads zero and idle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) rd(i, 31 - i);
        // Same-cycle conflict on reg 3: port 1 wins, bypassed and stored.
        cyc(0, 1, 3, 64'h11, 1, 3, 64'h22, 0, 0, 3, 3);
        rd(3, 3);
        // WAW: claim 5, drop port-0 write, load return writes and clears.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 5);
        cyc(0, 1, 5, 64'hAA, 0, 0, 0, 0, 0, 5, 5);
        cyc(0, 0, 0, 0, 1, 5, 64'hBB, 0, 0, 5, 5);
        rd(5, 5);
        rd(5, 0);
        // Claim/clear race on reg 7.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
        cyc(0, 0, 0, 0, 1, 7, 64'h5, 1, 7, 7, 7);
        rd(7, 7);
        // Zero register (reg 7 in the small configuration is ordinary).
        cyc(0, 0, 0, 0, 1, 31, 64'hFFFF, 1, 31, 31, 31);
        rd(31, 31);
        rd(31, 7);
        // Reset mid-operation discards busy state and a same-cycle claim.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
        rd(1, 2);
        rd(3, 4);
        // Randomized traffic, biased toward a few addresses to force collisions.
        for (int n = 0; n < 600; n++) begin
            ad0 = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            ad1 = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            cad = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 1) == 1, ad0, {$urandom, $urandom},
                $urandom_range(0, 2) == 0, ad1, {$urandom, $urandom},
                $urandom_range(0, 2) == 0, cad,
                $urandom_range(0, 1) ? ad0 : int'($urandom_range(0, 31)),
                $urandom_range(0, 1) ? cad : int'($urandom_range(0, 31)));
        end
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
